vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 108 ++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, blank, active-low syncs, frame pulse and count.
// Optional macro VGA_SYNC_DELAY_EN delays hs/vs by two pixel clocks.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int unsigned CW     = 10;
  localparam int unsigned KW     = CW + 1;
  localparam int unsigned H_T    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_T    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG = H_ACTIVE + H_FP;
  localparam int unsigned HS_END = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG = V_ACTIVE + V_FP;
  localparam int unsigned VS_END = VS_BEG + V_SYNC;

  // Counters are 10 bits wide; larger periods cannot be represented.
  if ((H_T > 1024) || (V_T > 1024)) begin : g_period_check
    $error("vga_timing_gen: H_T (%0d) and V_T (%0d) must not exceed 1024", H_T, V_T);
  end

  logic [CW-1:0] next_x;
  logic [CW-1:0] next_y;
  logic          x_wrap;
  logic          next_blank;
  logic          next_hs;
  logic          next_vs;
  logic          next_frame;

  // Next-count values; registered outputs decode these so they line up with DrawX/DrawY.
  always_comb begin
    x_wrap     = (DrawX == CW'(H_T - 1));
    next_x     = x_wrap ? '0 : DrawX + CW'(1);
    next_y     = DrawY;
    if (x_wrap) begin
      next_y = (DrawY == CW'(V_T - 1)) ? '0 : DrawY + CW'(1);
    end
    next_blank = (KW'(next_x) < KW'(H_ACTIVE)) && (KW'(next_y) < KW'(V_ACTIVE));
    next_hs    = !((KW'(next_x) >= KW'(HS_BEG)) && (KW'(next_x) < KW'(HS_END)));
    next_vs    = !((KW'(next_y) >= KW'(VS_BEG)) && (KW'(next_y) < KW'(VS_END)));
    next_frame = x_wrap && (next_y == '0);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      DrawX       <= '0;
      DrawY       <= '0;
      blank       <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      DrawX       <= next_x;
      DrawY       <= next_y;
      blank       <= next_blank;
      frame_start <= next_frame;
      if (next_frame) begin
        frame_count <= frame_count + 8'(1);
      end
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  // Two extra stages cover the downstream sprite ROM and output register latency.
  logic [1:0] hs_pipe;
  logic [1:0] vs_pipe;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_pipe <= 2'b11;
      vs_pipe <= 2'b11;
      hs      <= 1'b1;
      vs      <= 1'b1;
    end else begin
      hs_pipe <= {hs_pipe[0], next_hs};
      vs_pipe <= {vs_pipe[0], next_vs};
      hs      <= hs_pipe[1];
      vs      <= vs_pipe[1];
    end
  end
`else
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs <= 1'b1;
      vs <= 1'b1;
    end else begin
      hs <= next_hs;
      vs <= next_vs;
    end
  end
`endif

endmodule
